mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: WIDTH, default 5, operand width in bits; product width is 2*WIDTH.
REQ-002 CLOCK_50  input  1  single system clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request; level, held until gnt0.
REQ-005 a0, b0  input  WIDTH each  requester 0 multiplicand and multiplier; stable while req0 high and gnt0 low.
REQ-006 req1  input  1  requester 1 operation request; same rules as req0.
REQ-007 a1, b1  input  WIDTH each  requester 1 multiplicand and multiplier; same rules as a0, b0.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: operands of that requester were captured.
REQ-009 busy  output  1  high while an operation is in progress (CALC or DONE).
REQ-010 done  output  1  one-cycle pulse: product is valid.
REQ-011 done_id  output  1  requester owning the current product (0 or 1).
REQ-012 product  output  2*WIDTH  unsigned product; holds its value until the next done.

Function
REQ-013 The FSM shall have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE with any req high, the block shall grant one requester, capture its a (zero-extended to 2*WIDTH) as mcand and its b as mplier, clear acc and count, and go to CALC on the same edge.
REQ-015 With both requests high in IDLE, the requester holding round-robin priority shall win; after each grant, priority shall pass to the other requester.
REQ-016 gnt of the winner shall be high for exactly the first CALC cycle; the requester shall drop req in that cycle, otherwise it is treated as a new request at the next IDLE.
REQ-017 Each CALC cycle shall: add mcand to acc if mplier[0]=1; shift mcand left 1; shift mplier right 1; increment count.
REQ-018 CALC shall last exactly WIDTH cycles, then go to DONE (unless modified by REQ-025).
REQ-019 On the CALC-to-DONE edge, product shall load the final acc and done_id shall load the granted requester.
REQ-020 DONE shall last one cycle with done high, then go to IDLE; a new grant may occur in that following IDLE cycle.
REQ-021 Latency: done shall be high exactly WIDTH cycles after the gnt cycle; the minimum issue interval shall be WIDTH+2 cycles.
REQ-022 acc shall be 2*WIDTH bits wide, and no overflow shall be possible, because (2^WIDTH-1)^2 < 2^(2*WIDTH).
REQ-023 Requests arriving while busy shall be ignored and shall receive no grant until IDLE.

Reset
REQ-024 When RESET is high at a clock edge: state = IDLE; gnt0, gnt1, busy, done, done_id = 0; product = 0; acc, mcand, mplier and count = 0; priority = requester 0. A reset during CALC or DONE shall abandon the operation with no done pulse.

Configuration
REQ-025 Macro MULT_ARB_EARLY_EXIT_EN: when defined, CALC shall exit to DONE after any cycle in which the shifted mplier becomes zero (minimum 1 CALC cycle), so done is high N cycles after gnt, where N = max(1, bit-length of b).
REQ-026 Without MULT_ARB_EARLY_EXIT_EN, CALC shall always last exactly WIDTH cycles; product values shall be identical in both builds.

Verification (WIDTH=5)
REQ-027 req0 with a0=31, b0=31 -> gnt0 one cycle, then done 5 cycles later; product=961, done_id=0.
REQ-028 req0 and req1 high together, (3,4) and (6,7), after reset -> requester 0 granted first (product=12, done_id=0), then requester 1 (product=42, done_id=1); grants are WIDTH+2=7 cycles apart.
REQ-029 req1 with a1=0, b1=17 -> product=0, done_id=1; a later req0 with a0=17, b0=0 -> product=0.
REQ-030 RESET pulsed during the 3rd CALC cycle of 9*9 -> no done; all outputs 0; a next req1 alone is granted; a later simultaneous request is won by requester 0.
REQ-031 req0 held high through DONE with a1=5, b1=5 pending on req1 -> requester 1 granted next (round-robin); product=25.
REQ-032 With MULT_ARB_EARLY_EXIT_EN defined, a0=7, b0=2 -> done 2 cycles after gnt0, product=14; without the macro, done 5 cycles after gnt0, product=14.

Source files
------------

// File: rtl/mult_arbiter.sv
// Two-requester round-robin arbiter in front of a shift-add unsigned multiplier.
// Optional MULT_ARB_EARLY_EXIT_EN ends CALC as soon as the remaining multiplier bits are zero.
module mult_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    mcand, acc, acc_add;
  logic [WIDTH-1:0] mplier, mplier_shift;
  logic [CW-1:0]    count;
  logic             prio, owner;
  logic             any_req, winner, last_calc;

  always_comb begin
    any_req      = req0 | req1;
    winner       = (req0 && req1) ? prio : req1;
    mplier_shift = mplier >> 1;
    acc_add      = mplier[0] ? (acc + mcand) : acc;
`ifdef MULT_ARB_EARLY_EXIT_EN
    last_calc    = (mplier_shift == '0) || (count == CW'(WIDTH - 1));
`else
    last_calc    = (count == CW'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CALC;
      CALC:    if (last_calc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant capture in IDLE, one shift-add step per CALC cycle, result latch on the exit edge.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done_id <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      prio    <= 1'b0;
      owner   <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mcand  <= {{WIDTH{1'b0}}, (winner ? a1 : a0)};
            mplier <= winner ? b1 : b0;
            acc    <= '0;
            count  <= '0;
            owner  <= winner;
            prio   <= ~winner;
            gnt0   <= ~winner;
            gnt1   <= winner;
          end
        end
        CALC: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier_shift;
          count  <= count + 1'b1;
          if (last_calc) begin
            product <= acc_add;
            done_id <= owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter against a transaction-level model of
// round-robin granting, a*b products and done latency.
module tb_mult_arbiter;

  localparam int W = 5;

  logic           CLOCK_50 = 1'b0;
  logic           RESET;
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, busy, done, done_id;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int gnt_cyc = 0, gnt_cyc_prev = 0;
  bit m_prio = 1'b0;
  int m_prod = 0;

  mult_arbiter #(.WIDTH(W)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .product(product)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycles from the grant cycle to the done cycle.
  function automatic int model_lat(input logic [W-1:0] b);
`ifdef MULT_ARB_EARLY_EXIT_EN
    int n = 0;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return (n == 0) ? 1 : n;
`else
    return W;
`endif
  endfunction

  task automatic check_zero();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_product", product, 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check_zero();
    RESET = 1'b0;
    m_prio = 1'b0;
    m_prod = 0;
  endtask

  // Wait for the next grant, check the winner, then follow the operation to done.
  task automatic serve(input bit drop, output int lat);
    int w;
    bit win;
    logic [W-1:0] oa, ob;
    w = 0;
    lat = 0;
    do begin
      @(negedge CLOCK_50);
      w++;
      chk("prod_hold", product, m_prod);
    end while (!(gnt0 || gnt1) && w < 30);
    if (!(gnt0 || gnt1)) begin
      chk("gnt_timeout", 0, 1);
      return;
    end
    win = (req0 && req1) ? m_prio : req1;
    chk("gnt_id", gnt1, win);
    chk("gnt_onehot", int'(gnt0) + int'(gnt1), 1);
    chk("busy_gnt", busy, 1);
    oa = win ? a1 : a0;
    ob = win ? b1 : b0;
    m_prio = !win;
    gnt_cyc_prev = gnt_cyc;
    gnt_cyc = cyc;
    if (drop) begin
      if (win) req1 = 1'b0;
      else     req0 = 1'b0;
    end
    lat = model_lat(ob);
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLOCK_50);
      if (k == 1) chk("gnt_pulse", gnt0 | gnt1, 0);
      chk("busy", busy, 1);
      if (k < lat) chk("done_early", done, 0);
      else begin
        chk("done", done, 1);
        chk("product", product, int'(oa) * int'(ob));
        chk("done_id", done_id, win);
      end
    end
    m_prod = int'(oa) * int'(ob);
  endtask

  initial begin
    int lat, lat0, w;
    bit [1:0] r;
    RESET = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    do_reset();

    // Largest operands
    req0 = 1'b1; a0 = 5'd31; b0 = 5'd31;
    serve(1, lat);

    // Simultaneous requests right after reset; requester 0 first
    do_reset();
    req0 = 1'b1; a0 = 5'd3; b0 = 5'd4;
    req1 = 1'b1; a1 = 5'd6; b1 = 5'd7;
    serve(1, lat0);
    serve(1, lat);
    chk("issue_gap", gnt_cyc - gnt_cyc_prev, lat0 + 2);

    // Zero operands
    req1 = 1'b1; a1 = 5'd0; b1 = 5'd17;
    serve(1, lat);
    req0 = 1'b1; a0 = 5'd17; b0 = 5'd0;
    serve(1, lat);

    // Held request loses to the pending one on the next IDLE
    req1 = 1'b1; a1 = 5'd1; b1 = 5'd1;
    serve(1, lat);
    req0 = 1'b1; a0 = 5'd2; b0 = 5'd3;
    req1 = 1'b1; a1 = 5'd5; b1 = 5'd5;
    serve(0, lat);
    serve(1, lat);
    serve(1, lat);

    // Reset in the third CALC cycle abandons the operation
    req0 = 1'b1; a0 = 5'd9; b0 = 5'd9;
    w = 0;
    do begin @(negedge CLOCK_50); w++; end while (!gnt0 && w < 30);
    chk("rst_gnt_seen", gnt0, 1);
    req0 = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    check_zero();
    RESET = 1'b0;
    m_prio = 1'b0;
    m_prod = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge CLOCK_50);
      chk("no_done_after_rst", done, 0);
    end
    req1 = 1'b1; a1 = 5'd4; b1 = 5'd6;
    serve(1, lat);
    req0 = 1'b1; a0 = 5'd7; b0 = 5'd9;
    req1 = 1'b1; a1 = 5'd10; b1 = 5'd11;
    serve(1, lat);
    chk("rr_after_rst", done_id, 0);
    serve(1, lat);

    // Latency depends on build option
    req0 = 1'b1; a0 = 5'd7; b0 = 5'd2;
    serve(1, lat);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      r = 2'($urandom_range(1, 3));
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      req0 = r[0];
      req1 = r[1];
      serve(1, lat);
      if (req0 || req1) serve(1, lat);
      repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
